commit_trace_queue: RTL and testbench

//  Upstream feeder for the UART debug formatter. Captures ROB commit records
//  (up to 1/cycle), tags each with a 32-bit commit sequence number, and buffers

---
 rtl/commit_trace_queue_pkg.sv | 46 ++++
 rtl/commit_trace_queue_trace_fifo.sv | 58 +++++
 rtl/commit_trace_queue.sv | 123 ++++++++++++
 tb/tb_commit_trace_queue.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_queue_pkg.sv
// Shared definitions for the commit trace queue: record layout, work-type
// codes and the issue FSM encoding.
package commit_trace_queue_pkg;

    localparam int INFO_W   = 72;
    localparam int SEQ_W    = 32;
    localparam int ADDR_LSB = 0;
    localparam int TYPE_LSB = 32;
    localparam int RD_LSB   = 34;
    localparam int DATA_LSB = 40;
    localparam int REC_W    = SEQ_W + INFO_W;

    typedef enum logic [1:0] {
        WORK_REG    = 2'b00,
        WORK_STORE  = 2'b01,
        WORK_BRANCH = 2'b10
    } work_type_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } issue_state_e;

    // One buffered entry: sequence tag plus the raw commit record
    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [INFO_W-1:0] info;
    } trace_rec_t;

    // Assemble a commit record from its fields; bit 39 is unused and left zero
    function automatic logic [INFO_W-1:0] make_info(input logic [31:0] data,
                                                    input logic [4:0]  rd,
                                                    input work_type_e  wt,
                                                    input logic [31:0] addr);
        logic [INFO_W-1:0] r;
        r = '0;
        r[DATA_LSB +: 32] = data;
        r[RD_LSB   +: 5]  = rd;
        r[TYPE_LSB +: 2]  = wt;
        r[ADDR_LSB +: 32] = addr;
        return r;
    endfunction

endpackage

// File: rtl/commit_trace_queue_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is accepted
// only when a pop happens in the same cycle (the slot being read is reused).
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 104
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/commit_trace_queue.sv
// Commit trace queue: tags ROB commits with a sequence number, buffers them,
// and hands them one at a time to the slow UART formatter.
//
// Handshakes: the commit port has no ready; commit_stall (occupancy >= DEPTH-1)
// asks the ROB to hold, and a commit offered while full with no same-cycle pop
// is dropped and flagged in overflow. Toward the formatter, enable is a
// one-cycle pulse; the next record is offered only after fmt_busy has been
// seen high and then low again. rdy==0 freezes every register.
module commit_trace_queue
    import commit_trace_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              commit_valid,
    input  logic [INFO_W-1:0] commit_info,
    input  logic              fmt_busy,
    output logic              commit_stall,
    output logic              enable,
    output logic [SEQ_W-1:0]  count_finished,
    output logic [INFO_W-1:0] rob_info,
    output logic              overflow,
    output issue_state_e      dbg_state
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       occupancy;
    logic              fifo_full, fifo_empty;
    trace_rec_t        head_rec, push_rec;
    logic              pop_fire, push_fire, drop;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;

    issue_state_e      state_q;
    logic              enable_q;
    logic [SEQ_W-1:0]  count_finished_q;
    logic [INFO_W-1:0] rob_info_q;

    assign pop_fire  = rdy && (state_q == ST_IDLE) && !fifo_empty && !fmt_busy;
    assign push_fire = rdy && commit_valid && (!fifo_full || pop_fire);
    assign drop      = rdy && commit_valid && fifo_full && !pop_fire;
    assign push_rec  = '{seq: seq_q, info: commit_info};

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_fire),
        .wdata     (push_rec),
        .pop       (pop_fire),
        .rdata     (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    // Sequence counter advances only on accepted commits; overflow is sticky
    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q | drop;
        if (push_fire) seq_d = seq_q + 1'b1;
    end

    // Sequence and overflow registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
        end
    end

    // Issue FSM: present head record, pulse enable, wait out the formatter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            enable_q         <= 1'b0;
            count_finished_q <= '0;
            rob_info_q       <= '0;
        end else if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_fire) begin
                        count_finished_q <= head_rec.seq;
                        rob_info_q       <= head_rec.info;
                        enable_q         <= 1'b1;
                        state_q          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    enable_q <= 1'b0;
                    state_q  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (fmt_busy) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (!fmt_busy) state_q <= ST_IDLE;
                end
                default: begin
                    enable_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign commit_stall   = (occupancy >= (AW+1)'(DEPTH-1));
    assign enable         = enable_q;
    assign count_finished = count_finished_q;
    assign rob_info       = rob_info_q;
    assign overflow       = overflow_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Bench for commit_trace_queue: directed scenarios plus a randomized run,
// all checked every cycle against a transaction-level queue model.
module tb_commit_trace_queue;
    import commit_trace_queue_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b0;
    logic              commit_valid = 1'b0;
    logic [INFO_W-1:0] commit_info = '0;
    logic              fmt_busy = 1'b0;
    logic              commit_stall, enable, overflow;
    logic [SEQ_W-1:0]  count_finished;
    logic [INFO_W-1:0] rob_info;
    issue_state_e      dbg_state;

    always #5 clk = ~clk;

    commit_trace_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .commit_valid   (commit_valid),
        .commit_info    (commit_info),
        .fmt_busy       (fmt_busy),
        .commit_stall   (commit_stall),
        .enable         (enable),
        .count_finished (count_finished),
        .rob_info       (rob_info),
        .overflow       (overflow),
        .dbg_state      (dbg_state)
    );

    int checks = 0;
    int passed = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: expected queue of {seq, info} and formatter-protocol state
    logic [REC_W-1:0]  exp_q[$];
    logic [SEQ_W-1:0]  m_seq;
    logic              m_overflow, m_enable;
    logic              m_can_issue, m_skip, m_seen_busy;
    logic [SEQ_W-1:0]  m_count;
    logic [INFO_W-1:0] m_info;
    logic [SEQ_W-1:0]  emitted[$];

    // Formatter stand-in
    logic fmt_auto = 1'b1;
    logic fmt_raise = 1'b0;
    int   fmt_len = 0;

    task automatic model_reset();
        exp_q.delete();
        emitted.delete();
        m_seq       = '0;
        m_overflow  = 1'b0;
        m_enable    = 1'b0;
        m_can_issue = 1'b1;
        m_skip      = 1'b0;
        m_seen_busy = 1'b0;
        m_count     = '0;
        m_info      = '0;
    endtask

    function automatic logic [INFO_W-1:0] rand_info(input logic [31:0] addr);
        work_type_e wt;
        case ($urandom_range(0, 2))
            0:       wt = WORK_REG;
            1:       wt = WORK_STORE;
            default: wt = WORK_BRANCH;
        endcase
        return make_info($urandom, 5'($urandom_range(0, 31)), wt, addr);
    endfunction

    // One clock: predict, advance, then check outputs and run the formatter
    task automatic cycle();
        logic pop_e, push_e, drop_e;
        pop_e  = rdy && m_can_issue && (exp_q.size() > 0) && !fmt_busy;
        push_e = rdy && commit_valid && ((exp_q.size() < DEPTH) || pop_e);
        drop_e = rdy && commit_valid && (exp_q.size() == DEPTH) && !pop_e;
        @(posedge clk);
        if (rdy) begin
            m_enable = 1'b0;
            if (!m_can_issue) begin
                if (m_skip) m_skip = 1'b0;
                else if (!m_seen_busy) begin
                    if (fmt_busy) m_seen_busy = 1'b1;
                end else if (!fmt_busy) m_can_issue = 1'b1;
            end
            if (pop_e) begin
                {m_count, m_info} = exp_q.pop_front();
                m_enable    = 1'b1;
                m_can_issue = 1'b0;
                m_skip      = 1'b1;
                m_seen_busy = 1'b0;
            end
            if (push_e) begin
                exp_q.push_back({m_seq, commit_info});
                m_seq = m_seq + 1;
            end
            if (drop_e) m_overflow = 1'b1;
        end
        @(negedge clk);
        check_eq("enable", enable, m_enable);
        check_eq("commit_stall", commit_stall, exp_q.size() >= DEPTH-1);
        check_eq("overflow", overflow, m_overflow);
        check_eq("count_finished", count_finished, m_count);
        check_eq("rob_info", rob_info, m_info);
        if (enable) emitted.push_back(count_finished);
        if (fmt_auto && rdy) begin
            if (fmt_len > 0) begin
                fmt_len--;
                if (fmt_len == 0) fmt_busy = 1'b0;
            end else if (fmt_raise) begin
                fmt_raise = 1'b0;
                fmt_busy  = 1'b1;
                fmt_len   = $urandom_range(2, 12);
            end
            if (enable) fmt_raise = 1'b1;
        end
    endtask

    // Asynchronous reset applied between clock edges; outputs must clear at once
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_enable", enable, 0);
        check_eq("rst_count", count_finished, 0);
        check_eq("rst_info", rob_info, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_stall", commit_stall, 0);
        commit_valid = 1'b0;
        rdy = 1'b1;
        fmt_busy = 1'b0;
        fmt_auto = 1'b1;
        fmt_raise = 1'b0;
        fmt_len = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_one();
        commit_valid = 1'b1;
        commit_info  = rand_info($urandom);
        cycle();
        commit_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        commit_valid = 1'b0;
        rdy = 1'b1;
        fmt_auto = 1'b1;
        while ((exp_q.size() != 0 || !m_can_issue) && n < 600) begin
            cycle();
            n++;
        end
        check_eq("drain_done", n < 600, 1);
    endtask

    task automatic check_emitted(input string tag, input int cnt, input int first);
        check_eq({tag, "_count"}, emitted.size(), cnt);
        foreach (emitted[i]) check_eq({tag, "_seq"}, emitted[i], first + i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent, n, pulses;
        logic [INFO_W-1:0] t1_info;
        logic stall_seen;

        @(negedge clk);
        do_reset();

        // 1: single commit into idle queue
        t1_info = rand_info(32'h0000_1000);
        commit_valid = 1'b1;
        commit_info  = t1_info;
        cycle();
        commit_valid = 1'b0;
        check_eq("t1_no_early_enable", enable, 0);
        cycle();
        check_eq("t1_enable", enable, 1);
        check_eq("t1_seq0", count_finished, 0);
        check_eq("t1_info", rob_info, t1_info);
        pulses = 0;
        repeat (30) begin
            cycle();
            if (enable) pulses++;
        end
        check_eq("t1_single_pulse", pulses, 0);

        // 2: obedient ROB, formatter busy, stall at occupancy 7
        do_reset();
        fmt_auto = 1'b0;
        fmt_busy = 1'b1;
        sent = 0;
        stall_seen = 1'b0;
        for (int c = 0; c < 60 && sent < 8; c++) begin
            if (c == 14) begin
                fmt_busy = 1'b0;
                fmt_auto = 1'b1;
            end
            if (!commit_stall) begin
                commit_valid = 1'b1;
                commit_info  = rand_info($urandom);
                sent++;
            end else commit_valid = 1'b0;
            cycle();
            if (commit_stall && !stall_seen) begin
                stall_seen = 1'b1;
                check_eq("t2_stall_at7", exp_q.size(), 7);
            end
        end
        check_eq("t2_stall_seen", stall_seen, 1);
        drain();
        check_emitted("t2", 8, 0);
        check_eq("t2_no_overflow", overflow, 0);

        // 3: ROB ignores stall, 10 pushes while busy
        do_reset();
        fmt_auto = 1'b0;
        fmt_busy = 1'b1;
        commit_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            commit_info = rand_info($urandom);
            cycle();
        end
        commit_valid = 1'b0;
        check_eq("t3_overflow", overflow, 1);
        check_eq("t3_stall", commit_stall, 1);
        fmt_busy = 1'b0;
        drain();
        check_emitted("t3", 8, 0);
        emitted.delete();
        push_one();
        drain();
        check_emitted("t3_next", 1, 8);

        // 4: full FIFO, push and pop in the same cycle
        do_reset();
        fmt_auto = 1'b0;
        fmt_busy = 1'b1;
        repeat (8) push_one();
        cycle();
        fmt_busy = 1'b0;
        fmt_auto = 1'b1;
        commit_valid = 1'b1;
        commit_info = rand_info($urandom);
        cycle();
        commit_valid = 1'b0;
        check_eq("t4_enable", enable, 1);
        check_eq("t4_still_full", commit_stall, 1);
        check_eq("t4_no_drop", overflow, 0);
        drain();
        check_emitted("t4", 9, 0);

        // 5: rdy low for 5 cycles while waiting for the formatter to finish
        do_reset();
        repeat (4) push_one();
        n = 0;
        while (!enable && n < 50) begin cycle(); n++; end
        check_eq("t5_issue_seen", enable, 1);
        n = 0;
        while (!fmt_busy && n < 10) begin cycle(); n++; end
        check_eq("t5_busy_seen", fmt_busy, 1);
        cycle();
        rdy = 1'b0;
        fmt_auto = 1'b0;
        fmt_busy = 1'b0;
        fmt_len = 0;
        fmt_raise = 1'b0;
        commit_valid = 1'b1;
        repeat (5) begin
            commit_info = rand_info($urandom);
            cycle();
            check_eq("t5_frozen_enable", enable, 0);
        end
        commit_valid = 1'b0;
        rdy = 1'b1;
        fmt_auto = 1'b1;
        drain();
        check_emitted("t5", 4, 0);

        // 6: async reset with entries queued and FSM waiting for busy
        do_reset();
        fmt_auto = 1'b0;
        fmt_busy = 1'b0;
        repeat (6) push_one();
        repeat (2) cycle();
        check_eq("t6_queued", commit_stall, 0);
        do_reset();
        push_one();
        drain();
        check_emitted("t6", 1, 0);

        // 7: randomized traffic, rdy gaps, obedient and disobedient phases
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            commit_valid = ($urandom_range(0, 2) != 0) && ((c / 300) % 2 == 1 || !commit_stall);
            commit_info = rand_info($urandom);
            cycle();
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
